i2c_target: RTL

Single-address I2C target (slave) sitting on the same two-wire bus as the team's `i2c_controller`, oversampling SCL/SDA with the system clock. Decodes START/STOP, matches a 7-bit device address, hands each written byte to local logic as a one-cycle strobe, and serves read bytes requested from local logic. It never stretches SCL and drives SDA open-drain only: low or released.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_target_if.sv | 13 +
 rtl/i2c_bus_sync.sv | 41 ++++
 rtl/i2c_target.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels and the
// bit counter reload value used at every byte boundary.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [2:0] BIT_CNT_LOAD = 3'd7;

endpackage

// File: rtl/i2c_target_if.sv
// Local-side byte handshake of the I2C target: received bytes out,
// read bytes in, plus transfer status.
interface i2c_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       rw;

  modport slave  (output rx_data, rx_valid, tx_req, busy, rw, input tx_data);
  modport master (input rx_data, rx_valid, tx_req, busy, rw, output tx_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA oversampling: 2-FF synchronizers, one edge-detect stage, SCL edge
// strobes and START/STOP strobes in the clk domain.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_sync[1] & ~scl_d;
  assign scl_fall  = ~scl_sync[1] &  scl_d;
  assign start_det =  scl_sync[1] &  sda_d & ~sda_sync[1];
  assign stop_det  =  scl_sync[1] & ~sda_d &  sda_sync[1];

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: address match, write bytes out as strobes,
// read bytes fetched on request; SDA is open-drain, SCL never stretched.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i2c_scl,
  inout  wire          i2c_sda,
  i2c_target_if.slave  loc
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic [6:0] shift_q, shift_n;
  logic [6:0] tx_shift_q, tx_shift_n;
  logic       sda_low_q, sda_low_n;
  logic       ack_ok_q, ack_ok_n;
  logic [7:0] rx_data_q, rx_data_n;
  logic       rx_valid_q, rx_valid_n;
  logic       tx_req_q, tx_req_n;
  logic       busy_q, busy_n;
  logic       rw_q, rw_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= BIT_CNT_LOAD;
      shift_q    <= '0;
      tx_shift_q <= '0;
      sda_low_q  <= 1'b0;
      ack_ok_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      shift_q    <= shift_n;
      tx_shift_q <= tx_shift_n;
      sda_low_q  <= sda_low_n;
      ack_ok_q   <= ack_ok_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      tx_req_q   <= tx_req_n;
      busy_q     <= busy_n;
      rw_q       <= rw_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    shift_n    = shift_q;
    tx_shift_n = tx_shift_q;
    sda_low_n  = sda_low_q;
    ack_ok_n   = ack_ok_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy_q;
    rw_n       = rw_q;

    if (start_det) begin
      state_n   = ST_ADDR;
      cnt_n     = BIT_CNT_LOAD;
      sda_low_n = 1'b0;
      ack_ok_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = ST_IDLE;
      sda_low_n = 1'b0;
      ack_ok_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n = {shift_q[5:0], sda_s};
            if (cnt_q == 3'd0) begin
              if (shift_q == DEV_ADDR) begin
                rw_n     = sda_s;
                busy_n   = 1'b1;
                tx_req_n = sda_s;
                state_n  = ST_ADDR_ACK;
              end else begin
                state_n = ST_WAIT_STOP;
              end
            end else begin
              cnt_n = cnt_q - 3'd1;
            end
          end
        end
        // sda_low doubles as the phase flag: first fall pulls low, second ends the slot.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_n = 1'b1;
            end else if (rw_q) begin
              tx_shift_n = loc.tx_data[6:0];
              sda_low_n  = ~loc.tx_data[7];
              cnt_n      = BIT_CNT_LOAD;
              state_n    = ST_RD_BYTE;
            end else begin
              sda_low_n = 1'b0;
              cnt_n     = BIT_CNT_LOAD;
              state_n   = ST_WR_BYTE;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_n = {shift_q[5:0], sda_s};
            if (cnt_q == 3'd0) begin
              rx_data_n  = {shift_q, sda_s};
              rx_valid_n = 1'b1;
              state_n    = ST_WR_ACK;
            end else begin
              cnt_n = cnt_q - 3'd1;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_n = 1'b1;
            end else begin
              sda_low_n = 1'b0;
              cnt_n     = BIT_CNT_LOAD;
              state_n   = ST_WR_BYTE;
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_low_n = 1'b0;
              ack_ok_n  = 1'b0;
              state_n   = ST_RD_ACK;
            end else begin
              tx_shift_n = {tx_shift_q[5:0], 1'b0};
              sda_low_n  = ~tx_shift_q[6];
              cnt_n      = cnt_q - 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              tx_req_n = 1'b1;
              ack_ok_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall && ack_ok_q) begin
            tx_shift_n = loc.tx_data[6:0];
            sda_low_n  = ~loc.tx_data[7];
            ack_ok_n   = 1'b0;
            cnt_n      = BIT_CNT_LOAD;
            state_n    = ST_RD_BYTE;
          end
        end
        ST_WAIT_STOP: begin
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign i2c_sda      = sda_low_q ? 1'b0 : 1'bz;
  assign loc.rx_data  = rx_data_q;
  assign loc.rx_valid = rx_valid_q;
  assign loc.tx_req   = tx_req_q;
  assign loc.busy     = busy_q;
  assign loc.rw       = rw_q;

endmodule
